playfield_arbiter: RTL and testbench
====================================

PLAYFIELD_ARBITER -- requirements
Module: playfield_arbiter

Interface
REQ-001 SHALL have parameter COLS, default 10, playfield width in cells.
REQ-002 SHALL have parameter ROWS, default 20, playfield height in cells; DEPTH = COLS*ROWS = 200.
REQ-003 SHALL have parameter AW, default 8, cell address width.
REQ-004 SHALL have parameter DW, default 3, cell colour width (R,G,B bit).
REQ-005 SHALL have parameter TEAR_FREE, default 1; when 1, game writes are held until vertical blanking.
REQ-006 I_50MHZ_CLK  in  1  single system clock; all logic on its rising edge.
REQ-007 I_RESET  in  1  synchronous, active-high reset.
REQ-008 I_VBLANK  in  1  high during vertical blanking (between draw_finish and the next visible pixel).
REQ-009 I_VID_REQ  in  1  video renderer read request; at most one every 2 clocks (25 MHz pixel rate).
REQ-010 I_VID_ADDR  in  AW  video read cell address.
REQ-011 O_VID_DATA  out  DW  video read data.
REQ-012 O_VID_VALID  out  1  O_VID_DATA valid strobe.
REQ-013 I_GAME_REQ / I_GAME_WE  in  1 / 1  game-logic request; WE=1 write, WE=0 read.
REQ-014 I_GAME_ADDR / I_GAME_WDATA  in  AW / DW  game address and write data.
REQ-015 O_GAME_GNT  out  1  combinational grant; request is consumed in the cycle GNT=1.
REQ-016 O_GAME_RDATA / O_GAME_RVALID  out  DW / 1  game read data and valid strobe.
REQ-017 I_CLEAR  in  1  single-cycle pulse starting a playfield clear.
REQ-018 O_BUSY / O_CLEAR_DONE  out  1 / 1  clear in progress; one-cycle pulse at clear completion.

Function
REQ-019 SHALL own one single-port RAM of DEPTH x DW, synchronous read with 1-clock latency, one access per clock.
REQ-020 Priority per cycle SHALL be: video read > clear write > game access.
REQ-021 Video request in cycle N SHALL always be serviced: O_VID_VALID=1 and O_VID_DATA valid in cycle N+1, irrespective of other traffic.
REQ-022 O_GAME_GNT SHALL be 1 only when I_GAME_REQ=1, I_VID_REQ=0, state IDLE, and (WE=0 or TEAR_FREE=0 or I_VBLANK=1).
REQ-023 Granted game read in cycle N SHALL give O_GAME_RVALID=1 with data in cycle N+1; granted write SHALL update RAM at the end of cycle N.
REQ-024 Ungranted game request SHALL be held stable by the requester until granted; no queueing inside the block.
REQ-025 Address >= DEPTH: writes SHALL be discarded (GNT still given), reads SHALL return 0 with normal valid timing.
REQ-026 FSM states SHALL be IDLE and CLEAR; I_CLEAR in IDLE -> CLEAR next cycle with clear pointer = 0 and O_BUSY=1.
REQ-027 In CLEAR, each cycle without video request SHALL write 0 at the pointer and increment it; cycles with video request SHALL stall the pointer.
REQ-028 After writing address DEPTH-1 the FSM SHALL return to IDLE, pulse O_CLEAR_DONE for one cycle, drop O_BUSY the same cycle.
REQ-029 I_CLEAR while in CLEAR SHALL be ignored; I_CLEAR in the same cycle as a game grant SHALL let that access complete, clear starts the next cycle.
REQ-030 O_GAME_GNT SHALL be 0 throughout CLEAR; valid strobes SHALL be single-cycle, never both RAM results in one cycle for the same port.

Reset
REQ-031 On I_RESET: state IDLE, clear pointer 0, O_VID_VALID=0, O_GAME_RVALID=0, O_BUSY=0, O_CLEAR_DONE=0, O_VID_DATA=0, O_GAME_RDATA=0.
REQ-032 Reset mid-clear SHALL abort the clear without O_CLEAR_DONE; RAM contents are not reset and are unspecified for uncleared cells.

Structure
REQ-033 COLS, ROWS, DEPTH, AW, DW and the FSM state encoding SHALL live in shared package tetris_pkg.
REQ-034 The RAM SHALL be a separate sub-module playfield_ram (single port, sync read, write enable); arbitration and FSM stay in playfield_arbiter.

Verification
REQ-035 Game write addr 37 data 3'b101 in VBLANK, then video read addr 37 -> O_VID_DATA=3'b101 one cycle after request, O_VID_VALID=1.
REQ-036 Video and game read requested same cycle -> GNT=0, video data next cycle; game granted the following cycle, RVALID one cycle later.
REQ-037 TEAR_FREE=1, game write with I_VBLANK=0 for 10 cycles -> GNT=0 throughout; VBLANK rises -> GNT=1 same cycle, RAM updated.
REQ-038 I_CLEAR with no video traffic -> O_BUSY for 200 cycles, O_CLEAR_DONE pulse at cycle 201; all 200 cells read back 0.
REQ-039 I_CLEAR with video request every 2nd cycle -> clear takes 400 cycles, every video read valid at N+1, GNT=0 throughout.
REQ-040 I_RESET at clear cycle 50 -> O_BUSY=0 next cycle, no O_CLEAR_DONE; game read addr 210 afterwards -> RDATA=0, RVALID=1.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield geometry and arbiter FSM encoding.
package tetris_pkg;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = 8;
    localparam int DW    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } pf_state_t;

endpackage

// File: rtl/playfield_ram.sv
// Single-port playfield cell RAM, one access per clock.
// Latency: read data one clock after the address is presented.
// Backpressure: none; out-of-range writes are dropped, out-of-range reads return 0.
module playfield_ram #(
    parameter int DEPTH = tetris_pkg::DEPTH,
    parameter int AW    = tetris_pkg::AW,
    parameter int DW    = tetris_pkg::DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic          in_range;

    assign in_range = int'(addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[addr] <= wdata;
        end
        rdata <= in_range ? mem[addr] : '0;
    end

endmodule

// File: rtl/playfield_arbiter.sv
// Shares the playfield RAM between video reads, a background clear and game access.
// Latency: video and game reads return one clock after request/grant.
// Backpressure: video never stalls; game waits on GNT; clear stalls on video cycles.
module playfield_arbiter #(
    parameter int COLS      = tetris_pkg::COLS,
    parameter int ROWS      = tetris_pkg::ROWS,
    parameter int AW        = tetris_pkg::AW,
    parameter int DW        = tetris_pkg::DW,
    parameter int TEAR_FREE = 1
) (
    input  logic          I_50MHZ_CLK,
    input  logic          I_RESET,
    input  logic          I_VBLANK,
    input  logic          I_VID_REQ,
    input  logic [AW-1:0] I_VID_ADDR,
    output logic [DW-1:0] O_VID_DATA,
    output logic          O_VID_VALID,
    input  logic          I_GAME_REQ,
    input  logic          I_GAME_WE,
    input  logic [AW-1:0] I_GAME_ADDR,
    input  logic [DW-1:0] I_GAME_WDATA,
    output logic          O_GAME_GNT,
    output logic [DW-1:0] O_GAME_RDATA,
    output logic          O_GAME_RVALID,
    input  logic          I_CLEAR,
    output logic          O_BUSY,
    output logic          O_CLEAR_DONE
);
    import tetris_pkg::*;

    localparam int            DEPTH    = COLS * ROWS;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    pf_state_t     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          done_q, done_d;
    logic          vid_vld_q, game_vld_q;
    logic          clr_wr, game_gnt;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;
        clr_wr   = 1'b0;
        game_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Writes wait for blanking so a frame never shows a half-updated field.
                game_gnt = I_GAME_REQ && !I_VID_REQ &&
                           (!I_GAME_WE || (TEAR_FREE == 0) || I_VBLANK);
                if (I_CLEAR) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                clr_wr = !I_VID_REQ;
                if (clr_wr) begin
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_addr  = I_GAME_ADDR;
        ram_wdata = I_GAME_WDATA;
        ram_we    = game_gnt && I_GAME_WE && (int'(I_GAME_ADDR) < DEPTH);
        if (I_VID_REQ) begin
            ram_addr = I_VID_ADDR;
            ram_we   = 1'b0;
        end else if (clr_wr) begin
            ram_addr  = ptr_q;
            ram_wdata = '0;
            ram_we    = 1'b1;
        end
    end

    always_ff @(posedge I_50MHZ_CLK) begin
        if (I_RESET) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            done_q     <= 1'b0;
            vid_vld_q  <= 1'b0;
            game_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            done_q     <= done_d;
            vid_vld_q  <= I_VID_REQ;
            game_vld_q <= game_gnt && !I_GAME_WE;
        end
    end

    playfield_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (I_50MHZ_CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Data is masked outside its strobe so both buses read 0 out of reset.
    assign O_VID_VALID   = vid_vld_q;
    assign O_VID_DATA    = vid_vld_q ? ram_rdata : '0;
    assign O_GAME_RVALID = game_vld_q;
    assign O_GAME_RDATA  = game_vld_q ? ram_rdata : '0;
    assign O_GAME_GNT    = game_gnt;
    assign O_BUSY        = (state_q == ST_CLEAR);
    assign O_CLEAR_DONE  = done_q;

endmodule

// File: tb/tb_playfield_arbiter.sv
// Randomised and directed checks of playfield_arbiter against a cell-array reference.
module tb_playfield_arbiter;

    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       rst, vblank, vid_req, game_req, game_we, clr;
    logic [7:0] vid_addr, game_addr;
    logic [2:0] game_wdata;
    logic [2:0] vid_dat, game_rdat;
    logic       vid_vld, gnt, game_rvld, busy, done;

    always #10 clk = ~clk;

    playfield_arbiter dut (
        .I_50MHZ_CLK   (clk),
        .I_RESET       (rst),
        .I_VBLANK      (vblank),
        .I_VID_REQ     (vid_req),
        .I_VID_ADDR    (vid_addr),
        .O_VID_DATA    (vid_dat),
        .O_VID_VALID   (vid_vld),
        .I_GAME_REQ    (game_req),
        .I_GAME_WE     (game_we),
        .I_GAME_ADDR   (game_addr),
        .I_GAME_WDATA  (game_wdata),
        .O_GAME_GNT    (gnt),
        .O_GAME_RDATA  (game_rdat),
        .O_GAME_RVALID (game_rvld),
        .I_CLEAR       (clr),
        .O_BUSY        (busy),
        .O_CLEAR_DONE  (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: cell contents, whether each cell is defined, and clear progress.
    logic [2:0] mdl   [DEPTH];
    bit         known [DEPTH];
    bit         m_busy = 0;
    bit         m_done = 0;
    int         m_cnt  = 0;
    bit         e_vid_vld = 0, e_vid_kn = 0, e_g_vld = 0, e_g_kn = 0;
    logic [2:0] e_vid_dat = '0, e_g_dat = '0;

    logic       s_gnt = 0, s_busy = 0, s_done = 0, s_vid_vld = 0, s_g_vld = 0;
    logic [2:0] s_vid_dat = '0, s_g_dat = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit cell_known(input logic [7:0] a);
        if (int'(a) >= DEPTH) return 1'b1;
        return known[a];
    endfunction

    function automatic logic [2:0] cell_val(input logic [7:0] a);
        if (int'(a) >= DEPTH) return 3'd0;
        return mdl[a];
    endfunction

    // One clock: check outputs at the falling edge, advance the reference, then
    // return just after the next rising edge so the caller can drive new inputs.
    task automatic cycle();
        bit exp_gnt;
        @(negedge clk);
        s_gnt = gnt; s_busy = busy; s_done = done;
        s_vid_vld = vid_vld; s_vid_dat = vid_dat;
        s_g_vld = game_rvld; s_g_dat = game_rdat;
        exp_gnt = game_req && !vid_req && !m_busy && (!game_we || vblank);
        check_eq("gnt", gnt, exp_gnt);
        check_eq("busy", busy, m_busy);
        check_eq("clear_done", done, m_done);
        check_eq("vid_valid", vid_vld, e_vid_vld);
        check_eq("game_rvalid", game_rvld, e_g_vld);
        if (e_vid_vld && e_vid_kn) check_eq("vid_data", vid_dat, e_vid_dat);
        if (e_g_vld && e_g_kn) check_eq("game_rdata", game_rdat, e_g_dat);

        e_vid_vld = vid_req;
        e_vid_kn  = cell_known(vid_addr);
        e_vid_dat = cell_val(vid_addr);
        e_g_vld   = exp_gnt && !game_we;
        e_g_kn    = cell_known(game_addr);
        e_g_dat   = cell_val(game_addr);
        m_done    = 0;
        if (rst) begin
            if (m_busy) for (int a = m_cnt; a < DEPTH; a++) known[a] = 0;
            m_busy  = 0;
            e_vid_vld = 0;
            e_g_vld   = 0;
        end else begin
            if (exp_gnt && game_we && int'(game_addr) < DEPTH) begin
                mdl[game_addr]   = game_wdata;
                known[game_addr] = 1;
            end
            if (m_busy) begin
                if (!vid_req) begin
                    mdl[m_cnt]   = 3'd0;
                    known[m_cnt] = 1;
                    m_cnt++;
                    if (m_cnt == DEPTH) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end else if (clr) begin
                m_busy = 1;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, done_at, gnt_in_clear;
        bit done_seen;

        rst = 1; vblank = 0; vid_req = 0; vid_addr = '0; game_req = 0; game_we = 0;
        game_addr = '0; game_wdata = '0; clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_vid_valid", vid_vld, 0);
        check_eq("rst_vid_data", vid_dat, 0);
        check_eq("rst_game_rvalid", game_rvld, 0);
        check_eq("rst_game_rdata", game_rdat, 0);
        @(posedge clk);
        #1;

        // Full clear with no video traffic.
        clr = 1; cycle(); clr = 0;
        nb = 0; done_at = 0; done_seen = 0;
        for (int i = 0; i < 450 && !done_seen; i++) begin
            cycle();
            if (s_busy) nb++;
            if (s_done) begin done_seen = 1; done_at = i + 1; end
        end
        check_eq("clr_done_seen", done_seen, 1);
        check_eq("clr_busy_cycles", nb, 200);
        check_eq("clr_done_cycle", done_at, 201);
        for (int a = 0; a < DEPTH; a++) begin
            vid_req = 1; vid_addr = 8'(a); cycle();
            vid_req = 0; cycle();
        end

        // Game write in blanking, then video readback.
        vblank = 1; game_req = 1; game_we = 1; game_addr = 8'd37; game_wdata = 3'b101;
        cycle();
        check_eq("wr37_gnt", s_gnt, 1);
        game_req = 0; vid_req = 1; vid_addr = 8'd37; cycle();
        vid_req = 0; cycle();
        check_eq("rd37_valid", s_vid_vld, 1);
        check_eq("rd37_data", s_vid_dat, 3'b101);

        // Simultaneous video and game read: video wins, game follows.
        vid_req = 1; vid_addr = 8'd37; game_req = 1; game_we = 0; game_addr = 8'd37;
        cycle();
        check_eq("coll_gnt0", s_gnt, 0);
        vid_req = 0; cycle();
        check_eq("coll_vid_valid", s_vid_vld, 1);
        check_eq("coll_gnt1", s_gnt, 1);
        game_req = 0; cycle();
        check_eq("coll_rvalid", s_g_vld, 1);
        check_eq("coll_rdata", s_g_dat, 3'b101);

        // Tear-free: write outside blanking waits for VBLANK.
        vblank = 0; game_req = 1; game_we = 1; game_addr = 8'd50; game_wdata = 3'b110;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("tear_hold_gnt", s_gnt, 0);
        end
        vblank = 1; cycle();
        check_eq("tear_vblank_gnt", s_gnt, 1);
        game_req = 0; vid_req = 1; vid_addr = 8'd50; cycle();
        vid_req = 0; cycle();
        check_eq("tear_rd_data", s_vid_dat, 3'b110);

        // Clear requested in the same cycle as a granted game read.
        game_req = 1; game_we = 0; game_addr = 8'd37; clr = 1; cycle();
        check_eq("clrgnt_gnt", s_gnt, 1);
        game_req = 0; clr = 0; cycle();
        check_eq("clrgnt_rvalid", s_g_vld, 1);
        check_eq("clrgnt_busy", s_busy, 1);
        for (int i = 0; i < 300 && m_busy; i++) cycle();
        cycle();

        // Randomised mixed traffic.
        for (int i = 0; i < 1500; i++) begin
            if (!game_req || s_gnt) begin
                game_req   = ($urandom_range(2) != 0);
                game_we    = 1'($urandom_range(1));
                game_addr  = 8'($urandom_range(255));
                game_wdata = 3'($urandom_range(7));
            end
            vid_req  = !vid_req && ($urandom_range(1) == 1);
            vid_addr = 8'($urandom_range(255));
            if ($urandom_range(7) == 0) vblank = !vblank;
            clr = ($urandom_range(399) == 0);
            cycle();
        end
        clr = 0; game_req = 0; vid_req = 0;
        for (int i = 0; i < 300 && m_busy; i++) cycle();
        cycle();

        // Clear with video every second cycle.
        clr = 1; cycle(); clr = 0;
        game_req = 1; game_we = 0; game_addr = 8'd5;
        nb = 0; done_seen = 0; gnt_in_clear = 0;
        for (int i = 0; i < 700 && !done_seen; i++) begin
            vid_req  = !vid_req;
            vid_addr = 8'($urandom_range(199));
            cycle();
            if (s_busy) begin
                nb++;
                if (s_gnt) gnt_in_clear++;
            end
            if (s_done) done_seen = 1;
        end
        check_eq("vclr_done_seen", done_seen, 1);
        check_eq("vclr_busy_cycles", nb, 400);
        check_eq("vclr_gnt_count", gnt_in_clear, 0);
        game_req = 0; vid_req = 0; cycle(); cycle();

        // Reset in the middle of a clear.
        clr = 1; cycle(); clr = 0;
        for (int i = 1; i < 50; i++) cycle();
        rst = 1; cycle(); rst = 0;
        cycle();
        check_eq("abort_busy", s_busy, 0);
        check_eq("abort_done", s_done, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_done) done_seen = 1;
        end
        check_eq("abort_no_done", done_seen, 0);
        game_req = 1; game_we = 0; game_addr = 8'd210; cycle();
        check_eq("oob_gnt", s_gnt, 1);
        game_req = 0; cycle();
        check_eq("oob_rvalid", s_g_vld, 1);
        check_eq("oob_rdata", s_g_dat, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
